// File: rtl/cpu_sequencer_pkg.sv
// Shared opcode constants, instruction field helpers and FSM state encoding
// for the mode-1 instruction sequencer.
package cpu_sequencer_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT      = 3'd3,
        S_ADVANCE   = 3'd4,
        S_HALTED    = 3'd5
`ifdef SEQ_STEP_EN
        ,
        S_STEP_HOLD = 3'd6
`endif
    } state_t;

    function automatic logic [2:0] f_op(input logic [7:0] i);
        return i[7:5];
    endfunction

    function automatic logic [4:0] f_opd(input logic [7:0] i);
        return i[4:0];
    endfunction

    // Opcodes 011..110 do nothing but advance the PC.
    function automatic logic is_nop(input logic [2:0] op);
        return (op >= 3'b011) && (op <= 3'b110);
    endfunction

endpackage

// File: rtl/cpu_sequencer_tmo.sv
// Saturating ALU-wait timeout counter; expired flags the cycle the
// count reaches MAX while counting.
module seq_tmo_ctr #(
    parameter int MAX = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt;

    assign expired = en && (cnt == 8'(MAX - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != 8'(MAX))) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Mode-1 instruction sequencer: fetch, decode, ALU handshake, PC advance.
// Define SEQ_STEP_EN to add the single-step port and STEP_HOLD state.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int ACC_W   = 8,
    parameter int TMO_MAX = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ena,
`ifdef SEQ_STEP_EN
    input  logic             step,
`endif
    input  logic [7:0]       instr_in,
    output logic             pc_adv,
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic [2:0]       alu_op,
    output logic [ACC_W-1:0] alu_a,
    output logic [ACC_W-1:0] alu_b,
    input  logic             alu_done,
    input  logic [ACC_W-1:0] alu_result,
    output logic [ACC_W-1:0] acc_out,
    output logic             busy,
    output logic             halted,
    output logic             err
);

    state_t     state;
    state_t     nxt;
    logic [7:0] ir;
    logic       tmo_exp;

    assign alu_op = f_op(ir);
    assign alu_a  = acc_out;
    assign alu_b  = ACC_W'(f_opd(ir));

    seq_tmo_ctr #(
        .MAX(TMO_MAX)
    ) u_tmo (
        .clock  (clock),
        .reset  (reset),
        .clr    (state == S_ISSUE && alu_ready),
        .en     (state == S_WAIT),
        .expired(tmo_exp)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:    if (ena) nxt = S_FETCH;
            S_FETCH: begin
                if (f_op(instr_in) == OP_HALT)
                    nxt = S_HALTED;
                else if (is_nop(f_op(instr_in)))
                    nxt = S_ADVANCE;
                else
                    nxt = S_ISSUE;
            end
            S_ISSUE:   if (alu_ready) nxt = S_WAIT;
            S_WAIT:    if (alu_done || tmo_exp) nxt = S_ADVANCE;
`ifdef SEQ_STEP_EN
            S_ADVANCE: nxt = ena ? S_STEP_HOLD : S_IDLE;
            S_STEP_HOLD: begin
                if (!ena)
                    nxt = S_IDLE;
                else if (step)
                    nxt = S_FETCH;
            end
`else
            S_ADVANCE: nxt = ena ? S_FETCH : S_IDLE;
`endif
            S_HALTED:  nxt = S_HALTED;
            default:   nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ir        <= '0;
            acc_out   <= '0;
            err       <= 1'b0;
            pc_adv    <= 1'b0;
            alu_valid <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= nxt;
            pc_adv    <= (nxt == S_ADVANCE);
            alu_valid <= (nxt == S_ISSUE);
            busy      <= (nxt == S_FETCH) || (nxt == S_ISSUE) ||
                         (nxt == S_WAIT)  || (nxt == S_ADVANCE);
            halted    <= (nxt == S_HALTED);
            if (state == S_FETCH)
                ir <= instr_in;
            if (state == S_WAIT) begin
                if (alu_done)
                    acc_out <= alu_result;
                else if (tmo_exp)
                    err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a behavioural ALU and an
// accumulator scoreboard checked on every pc_adv pulse.
module tb_cpu_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] instr_in;
    logic       pc_adv;
    logic       alu_valid;
    logic       alu_ready = 1'b1;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_done = 1'b0;
    logic [7:0] alu_result = '0;
    logic [7:0] acc_out;
    logic       busy;
    logic       halted;
    logic       err;
`ifdef SEQ_STEP_EN
    logic       step = 1'b1;
`endif

    always #5 clock = ~clock;

    cpu_sequencer #(.ACC_W(8), .TMO_MAX(15)) dut (
        .clock     (clock),
        .reset     (reset),
        .ena       (ena),
`ifdef SEQ_STEP_EN
        .step      (step),
`endif
        .instr_in  (instr_in),
        .pc_adv    (pc_adv),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_done  (alu_done),
        .alu_result(alu_result),
        .acc_out   (acc_out),
        .busy      (busy),
        .halted    (halted),
        .err       (err)
    );

    // Program ROM indexed by the bench-owned PC
    logic [7:0] rom [4];
    int         plen = 1;
    int         pc = 0;
    assign instr_in = rom[pc[1:0]];

    // Behavioural ALU: configurable ready hold-off, done delay, or no done
    int          dly = 1;
    int          hold_req = 0;
    bit          never = 1'b0;
    int          hcnt = 0;
    int          pend = 0;
    int          accepts = 0;
    int          unstable = 0;
    bit          vprev = 1'b0;
    logic [18:0] cap = '0;
    logic [7:0]  res = '0;

    always @(negedge clock) begin
        alu_done = 1'b0;
        if (reset) begin
            pend = 0;
            hcnt = hold_req;
            vprev = 1'b0;
            alu_ready = (hold_req == 0);
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0 && !never) begin
                    alu_done = 1'b1;
                    alu_result = res;
                end
            end
            if (alu_valid) begin
                if (hcnt > 0) begin
                    alu_ready = 1'b0;
                    hcnt--;
                end else begin
                    alu_ready = 1'b1;
                end
                if (!vprev)
                    cap = {alu_op, alu_a, alu_b};
                else if (cap !== {alu_op, alu_a, alu_b})
                    unstable++;
                if (alu_ready) begin
                    accepts++;
                    pend = dly;
                    case (alu_op)
                        3'b000:  res = alu_a + alu_b;
                        3'b001:  res = alu_a - alu_b;
                        3'b010:  res = 8'(alu_a * alu_b);
                        default: res = 8'hxx;
                    endcase
                end
            end else begin
                hcnt = hold_req;
                alu_ready = (hold_req == 0);
            end
            vprev = alu_valid;
        end
    end

    int         checks = 0;
    int         passed = 0;
    int         cyc_n = 0;
    int         adv_n = 0;
    int         valid_n = 0;
    int         last_adv = -1;
    int         last_valid = -1;
    bit         gap_chk = 1'b0;
    logic       err_prev = 1'b0;
    logic [7:0] expq[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock: update the PC, then sample outputs 1 time unit after the edge
    task automatic cyc();
        logic adv;
        adv = pc_adv;
        err_prev = err;
        @(posedge clock);
        if (adv)
            pc = (pc + 1) % plen;
        #1;
        cyc_n++;
        if (alu_valid) begin
            valid_n++;
            last_valid = cyc_n;
        end
        if (pc_adv) begin
            adv_n++;
            if (expq.size() > 0) begin
                chk("acc_at_adv", acc_out, expq.pop_front());
            end else begin
                checks++;
                $error("FAIL unexpected_adv observed=pc_adv expected=none");
            end
            if (gap_chk && last_adv >= 0)
                chk("adv_gap", cyc_n - last_adv, 4);
            last_adv = cyc_n;
        end
    endtask

    task automatic wait_adv(input int maxc, input string tag);
        int a0;
        int n;
        a0 = adv_n;
        n = 0;
        while (adv_n == a0 && n < maxc) begin
            cyc();
            n++;
        end
        chk(tag, adv_n - a0, 1);
    endtask

    task automatic wait_valid(input int maxc, input string tag);
        int n;
        n = 0;
        while (!alu_valid && n < maxc) begin
            cyc();
            n++;
        end
        chk(tag, alu_valid, 1);
    endtask

    task automatic rst();
        reset = 1'b1;
        ena = 1'b0;
        pc = 0;
        expq.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int a0;
        int v0;
        int u0;
        rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h00;

        #2 reset = 1'b1;
        #1;
        chk("rst_flags", {pc_adv, alu_valid, busy, halted, err}, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_alu_bus", {alu_op, alu_a, alu_b}, 0);
        rst();

        // ADD3,SUB2,MUL5,ADD0 then wrap to ADD3
        rom[0] = 8'h03; rom[1] = 8'h22; rom[2] = 8'h45; rom[3] = 8'h00;
        plen = 4;
        expq.push_back(8'd3);
        expq.push_back(8'd1);
        expq.push_back(8'd5);
        expq.push_back(8'd5);
        expq.push_back(8'd8);
        gap_chk = 1'b1;
        ena = 1'b1;
        for (int i = 0; i < 5; i++)
            wait_adv(20, "t1_adv");
        ena = 1'b0;
        gap_chk = 1'b0;
        cyc();
        chk("t1_pc_wrap", pc, 1);
        chk("t1_idle", busy, 0);
        chk("t1_sb_empty", expq.size(), 0);

        // ready held low for 3 ISSUE cycles
        rst();
        hold_req = 3;
        rom[0] = 8'h07;
        plen = 1;
        a0 = accepts;
        u0 = unstable;
        v0 = valid_n;
        expq.push_back(8'd7);
        ena = 1'b1;
        wait_adv(30, "t2_adv");
        ena = 1'b0;
        chk("t2_stable", unstable - u0, 0);
        chk("t2_accepts", accepts - a0, 1);
        chk("t2_valid_cycles", valid_n - v0, 4);
        hold_req = 0;
        cyc();

        // ALU never completes
        rst();
        never = 1'b1;
        rom[0] = 8'h01;
        plen = 1;
        expq.push_back(8'd0);
        a0 = adv_n;
        ena = 1'b1;
        wait_adv(40, "t3_adv");
        ena = 1'b0;
        chk("t3_wait_cycles", last_adv - last_valid - 1, 15);
        chk("t3_err", err, 1);
        chk("t3_err_prev", err_prev, 0);
        repeat (20) cyc();
        chk("t3_err_sticky", err, 1);
        chk("t3_one_adv", adv_n - a0, 1);
        chk("t3_acc", acc_out, 0);
        never = 1'b0;

        // HALT after ADD3
        rst();
        rom[0] = 8'h03; rom[1] = 8'hE0;
        plen = 2;
        expq.push_back(8'd3);
        ena = 1'b1;
        wait_adv(20, "t4_adv");
        repeat (3) cyc();
        chk("t4_halted", halted, 1);
        a0 = adv_n;
        v0 = valid_n;
        repeat (50) cyc();
        chk("t4_no_adv", adv_n - a0, 0);
        chk("t4_no_valid", valid_n - v0, 0);
        chk("t4_still_halted", halted, 1);
        chk("t4_not_busy", busy, 0);
        chk("t4_acc", acc_out, 3);
        reset = 1'b1;
        #1;
        chk("t4_rst_halted", halted, 0);
        chk("t4_rst_acc", acc_out, 0);

        // ena dropped during WAIT
        rst();
        dly = 3;
        rom[0] = 8'h04; rom[1] = 8'h21;
        plen = 2;
        expq.push_back(8'd4);
        ena = 1'b1;
        wait_valid(20, "t5_issue_seen");
        cyc();
        chk("t5_in_wait", {busy, alu_valid, pc_adv}, 3'b100);
        ena = 1'b0;
        wait_adv(20, "t5_adv");
        cyc();
        chk("t5_idle", busy, 0);
        a0 = adv_n;
        repeat (5) cyc();
        chk("t5_parked", adv_n - a0, 0);
        ena = 1'b1;
        expq.push_back(8'd3);
        cyc();
        chk("t5_restart_fetch", {busy, alu_valid, pc_adv}, 3'b100);
        wait_adv(20, "t5_adv2");
        ena = 1'b0;
        cyc();
        dly = 1;

        // async reset while ISSUE is pending
        rst();
        hold_req = 100;
        rom[0] = 8'h01;
        plen = 1;
        ena = 1'b1;
        wait_valid(20, "t6_valid");
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid_async", alu_valid, 0);
        chk("t6_busy_async", busy, 0);
        ena = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        hold_req = 0;
        cyc();
        cyc();
        chk("t6_idle", {busy, halted, alu_valid, pc_adv}, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
